elm_neuron_mac: RTL and testbench
=================================

Name: elm_neuron_mac

Overview:
Upstream feeder for the hidden-layer accumulator register in the ELM datapath. It takes a stream of (input sample, weight) pairs in signed Q8.8. It computes their dot product with a 2-stage multiply/add pipeline and saturates the result to DATA_W. It then drives the accumulator register's data_in, load and RST (clear) inputs: one clear pulse per neuron at start, and one load pulse when the result is final.

Parameters:
DATA_W, 16, width of x_in, w_in and acc_out; signed Q8.8 fixed point (FRAC=8 fixed).
N_IN, 8, number of (x, w) pairs per neuron dot product; legal range 1..2^CNT_W.
CNT_W, 4, width of the accepted-pair counter.
GUARD, 4, extra MSBs on the internal running sum.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  begin a new neuron; sampled only in IDLE.
x_in  input  DATA_W  input sample, signed Q8.8.
w_in  input  DATA_W  weight, signed Q8.8.
in_valid  input  1  x_in/w_in valid.
in_ready  output  1  block accepts a pair this cycle.
acc_out  output  DATA_W  saturated dot product; drives the accumulator data_in.
acc_load  output  1  one-cycle load strobe to the accumulator.
acc_clr  output  1  one-cycle clear strobe to the accumulator RST input.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse, coincident with acc_load.

Behaviour:
- Reset (rst=0, async): state=IDLE. Counter, sum, product register and pipe-valid flags are 0. All outputs are 0, including acc_out=0.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- FSM states: IDLE, CLEAR, ACCUM, DRAIN, WRITE.
- IDLE: in_ready=0, busy=0. start=1 moves to CLEAR next edge.
- CLEAR (1 cycle): acc_clr=1. Sum and count are cleared. Next state is ACCUM.
- ACCUM: in_ready=1. Handshake = in_valid & in_ready. Each handshake increments the count.
  - A handshake when count==N_IN-1 moves to DRAIN.
  - in_valid gaps (bubbles) are allowed and do not change state.
- DRAIN (exactly 2 cycles): in_ready=0. Lets the product and add stages empty. Then moves to WRITE.
- WRITE (1 cycle): acc_out is loaded with sat(sum), and acc_load=1 and done=1 in the same cycle. Next state is IDLE.
- Latency: the edge that accepts the last pair is edge k. acc_load, done and the new acc_out all become visible after edge k+3. From start sampled to first in_ready=1 is 2 edges.
- acc_out holds its value until the next WRITE. The CLEAR state does not alter acc_out.
- Pipeline:
  - Stage 1 registers p = (x_in*w_in) >>> 8, taken from the full 2*DATA_W signed product by arithmetic shift (truncation toward -inf).
  - p is saturated to DATA_W: values above 0x7FFF clamp to 0x7FFF; values below 0x8000 clamp to 0x8000.
  - Stage 2 adds the sign-extended p into a sum of width DATA_W+GUARD.
- Output saturation: acc_out = sum clamped to [0x8000, 0x7FFF]. The sum never wraps internally for N_IN ≤ 2^GUARD.
- start while busy=1 is ignored, with no queueing.
- start held high through WRITE restarts only after re-entering IDLE. IDLE samples start on the next edge, so a continuously high start gives back-to-back neurons with one IDLE cycle between them.
- in_valid is ignored outside ACCUM. Data presented while in_ready=0 is not consumed.
- Reset mid-operation aborts immediately with no acc_load or done. The downstream register keeps whatever it last loaded.
- N_IN=1: CLEAR → ACCUM (1 pair) → DRAIN → WRITE. Same 3-edge latency.

Test Plan:
- Reset, then N_IN=8 pairs of x=0x0100 (1.0) and w=0x0080 (0.5), in_valid held high → acc_clr pulses once, in_ready high 8 cycles, acc_out=0x0400 with acc_load=done=1 for one cycle, 3 edges after the last handshake.
- 8 pairs of x=0xFF00 (-1.0), w=0x0100, with in_valid low on alternate cycles → acc_out=0xF800, exactly 8 handshakes counted, same 3-edge tail latency.
- 8 pairs of x=w=0x7FFF → each product clamps to 0x7FFF and acc_out=0x7FFF. Then x=0x8000, w=0x7FFF → acc_out=0x8000.
- Mixed signs: x=0x0180 (1.5) × w=0xFF80 (-0.5) for 8 pairs → acc_out=0xFA00 (-6.0).
- Pulse start during ACCUM/DRAIN → no state change and no second acc_clr. Hold start high continuously → consecutive neurons separated by one IDLE cycle.
- Assert rst low after 4 handshakes → outputs go to 0 asynchronously with no acc_load. After release, a full run gives the correct result from fresh.

Source files
------------

// File: rtl/elm_neuron_mac.sv
// elm_neuron_mac
//   Feeds the ELM hidden-layer accumulator register. Consumes N_IN signed
//   Q8.8 (x, w) pairs, forms their dot product through a two-stage
//   multiply/add pipeline, saturates the result to DATA_W, and drives the
//   accumulator's data_in (acc_out), load (acc_load) and clear (acc_clr).
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   start     in   begin a new neuron (sampled in IDLE only)
//   x_in      in   input sample, signed Q8.8
//   w_in      in   weight, signed Q8.8
//   in_valid  in   x_in/w_in valid
//   in_ready  out  pair accepted this cycle when in_valid is also high
//   acc_out   out  saturated dot product, held until the next WRITE
//   acc_load  out  one-cycle load strobe
//   acc_clr   out  one-cycle clear strobe
//   busy      out  high in every state except IDLE
//   done      out  one-cycle completion pulse, coincident with acc_load
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// CLEAR | pulse acc_clr, zero the running sum and pair counter
// ACCUM | accept pairs until N_IN handshakes
// DRAIN | two cycles for the product and add stages to empty
// WRITE | register sat(sum) into acc_out, strobe acc_load/done
module elm_neuron_mac #(
    parameter int DATA_W = 16,
    parameter int N_IN   = 8,
    parameter int CNT_W  = 4,
    parameter int GUARD  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] acc_out,
    output logic              acc_load,
    output logic              acc_clr,
    output logic              busy,
    output logic              done
);

    localparam int FRAC  = 8;
    localparam int PW    = 2 * DATA_W;
    localparam int SUM_W = DATA_W + GUARD;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain_q, drain_d;
    logic [DATA_W-1:0] p_q, p_d;
    logic              p_vld_q;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] acc_out_q;
    logic              acc_load_q;
    logic              done_q;

    logic              hs;
    logic signed [PW-1:0] x_ext, w_ext, prod, prod_sh;
    logic [DATA_W:0]   prod_top;
    logic [GUARD:0]    sum_top;
    logic [DATA_W-1:0] sum_sat;

    assign in_ready = (state_q == S_ACCUM);
    assign acc_clr  = (state_q == S_CLEAR);
    assign busy     = (state_q != S_IDLE);
    assign acc_out  = acc_out_q;
    assign acc_load = acc_load_q;
    assign done     = done_q;

    assign hs = in_valid & in_ready;

    // Stage 1: full-width signed product, arithmetic shift drops the extra
    // fraction bits (rounds toward -inf), then clamp to DATA_W.
    assign x_ext   = {{DATA_W{x_in[DATA_W-1]}}, x_in};
    assign w_ext   = {{DATA_W{w_in[DATA_W-1]}}, w_in};
    assign prod    = x_ext * w_ext;
    assign prod_sh = prod >>> FRAC;
    // Result fits when every bit from the DATA_W sign position up agrees.
    assign prod_top = prod_sh[PW-1:DATA_W-1];

    always_comb begin
        p_d = prod_sh[DATA_W-1:0];
        if (!((&prod_top) || (~|prod_top))) begin
            p_d = prod_sh[PW-1] ? MAX_NEG : MAX_POS;
        end
    end

    // Stage 2 and output clamp.
    assign sum_d   = sum_q + {{GUARD{p_q[DATA_W-1]}}, p_q};
    assign sum_top = sum_q[SUM_W-1:DATA_W-1];

    always_comb begin
        sum_sat = sum_q[DATA_W-1:0];
        if (!((&sum_top) || (~|sum_top))) begin
            sum_sat = sum_q[SUM_W-1] ? MAX_NEG : MAX_POS;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Down-counter: two DRAIN cycles (1 then 0).
                if (drain_q == 1'b0) state_d = S_WRITE;
                else                 drain_d = drain_q - 1'b1;
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            p_q        <= '0;
            p_vld_q    <= 1'b0;
            sum_q      <= '0;
            acc_out_q  <= '0;
            acc_load_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;

            p_vld_q <= hs;
            if (hs) p_q <= p_d;

            if (state_q == S_CLEAR) sum_q <= '0;
            else if (p_vld_q)       sum_q <= sum_d;

            acc_load_q <= (state_q == S_WRITE);
            done_q     <= (state_q == S_WRITE);
            if (state_q == S_WRITE) acc_out_q <= sum_sat;
        end
    end

endmodule

// File: tb/tb_elm_neuron_mac.sv
module tb_elm_neuron_mac;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] acc_out;
    logic        acc_load;
    logic        acc_clr;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int clr_cnt  = 0;
    int load_cnt = 0;
    logic [15:0] last_out = 16'h0000;

    elm_neuron_mac #(.DATA_W(16), .N_IN(8), .CNT_W(4), .GUARD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_in     (x_in),
        .w_in     (w_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .acc_out  (acc_out),
        .acc_load (acc_load),
        .acc_clr  (acc_clr),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (acc_clr)  clr_cnt  = clr_cnt + 1;
        if (acc_load) load_cnt = load_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one neuron of 8 identical pairs. Called at posedge+1.
    // already: state is CLEAR on entry (start was held through the previous run).
    // hold: keep start high and check the next neuron's clear follows one IDLE cycle.
    task automatic run_neuron(input string tag, input logic [15:0] x, input logic [15:0] w,
                              input bit gap, input bit pulse_mid, input bit hold,
                              input bit already, input logic [15:0] exp);
        int clr_base;
        int hs_cnt;
        int rdy_cnt;
        bit hs_now;
        bit ok;
        clr_base = clr_cnt;
        if (!already) begin
            start = 1'b1;
            @(posedge clk); #1;
        end
        start = hold;
        check({tag, "_clr"}, {31'd0, acc_clr}, 32'd1);
        check({tag, "_clr_rdy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_hold_out"}, {16'd0, acc_out}, {16'd0, last_out});
        x_in = x;
        w_in = w;
        hs_cnt = 0;
        rdy_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_valid = gap ? (i % 2 == 0) : 1'b1;
            if (pulse_mid && !hold) start = (i == 3);
            hs_now = in_valid & in_ready;
            if (in_ready) rdy_cnt++;
            @(posedge clk); #1;
            if (hs_now) hs_cnt++;
            if (hs_cnt == 8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_timeout"}, 32'd1, 32'd0);
        in_valid = 1'b0;
        if (!hold) start = 1'b0;
        check({tag, "_rdy_cycles"}, rdy_cnt, gap ? 32'd16 : 32'd8);
        check({tag, "_drain_rdy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_k0_load"}, {31'd0, acc_load}, 32'd0);
        if (pulse_mid) start = 1'b1;
        @(posedge clk); #1;
        check({tag, "_k1_load"}, {31'd0, acc_load}, 32'd0);
        if (pulse_mid) start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_k2_load"}, {31'd0, acc_load}, 32'd0);
        check({tag, "_k2_busy"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_k3_load"}, {31'd0, acc_load}, 32'd1);
        check({tag, "_k3_done"}, {31'd0, done}, 32'd1);
        check({tag, "_acc_out"}, {16'd0, acc_out}, {16'd0, exp});
        check({tag, "_clr_pulses"}, clr_cnt - clr_base, 32'd1);
        last_out = exp;
        @(posedge clk); #1;
        check({tag, "_k4_load"}, {31'd0, acc_load}, 32'd0);
        if (hold) begin
            check({tag, "_b2b_clr"}, {31'd0, acc_clr}, 32'd1);
        end else begin
            check({tag, "_k4_busy"}, {31'd0, busy}, 32'd0);
            check({tag, "_k4_out"}, {16'd0, acc_out}, {16'd0, exp});
        end
    endtask

    initial begin
        int hs_cnt;
        int load_base;
        bit hs_now;
        rst = 1'b0;
        start = 1'b0;
        x_in = '0;
        w_in = '0;
        in_valid = 1'b0;
        #2;
        check("rst_out", {16'd0, acc_out}, 32'd0);
        check("rst_load", {31'd0, acc_load}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_clr", {31'd0, acc_clr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdy", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_neuron("half", 16'h0100, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0400);
        run_neuron("neg_gap", 16'hFF00, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF800);
        run_neuron("sat_pos", 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF);
        run_neuron("sat_neg", 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000);
        run_neuron("mixed", 16'h0180, 16'hFF80, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFA00);
        run_neuron("b2b_a", 16'h0100, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0400);
        run_neuron("b2b_b", 16'hFF00, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 16'hF800);

        // Abort after 4 handshakes.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x_in = 16'h0100;
        w_in = 16'h0100;
        hs_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            hs_now = in_ready;
            @(posedge clk); #1;
            if (hs_now) hs_cnt++;
            if (hs_cnt == 4) break;
        end
        check("abort_hs", hs_cnt, 32'd4);
        #2 rst = 1'b0;
        #1;
        check("abort_out", {16'd0, acc_out}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rdy", {31'd0, in_ready}, 32'd0);
        check("abort_load", {31'd0, acc_load}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        load_base = load_cnt;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_load", load_cnt - load_base, 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        last_out = 16'h0000;
        @(posedge clk); #1;
        run_neuron("fresh", 16'h0180, 16'hFF80, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFA00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
